// File: rtl/microseq_pkg.sv
// microseq_pkg: shared types and microword field helpers for the microcode
// sequencer. The microword layout, MSB first, is {op[1:0], csel, target, ctrl}.
package microseq_pkg;

  typedef enum logic [1:0] {
    OP_NEXT = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int OP_W     = 2;
  localparam int CTRL_LSB = 0;

  function automatic int data_width(int aw, int cw, int sw);
    return OP_W + sw + aw + cw;
  endfunction

  function automatic int tgt_lsb(int cw);
    return cw;
  endfunction

  function automatic int csel_lsb(int aw, int cw);
    return cw + aw;
  endfunction

  function automatic int op_lsb(int aw, int cw, int sw);
    return cw + aw + sw;
  endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// microcode_sequencer_if: command, ROM and datapath signals of the sequencer.
//   master: command decoder / ROM / datapath side (drives start, start_addr,
//           cond_in, rom_data; observes rom_addr, ctrl_out, busy, done, err)
//   slave : the sequencer itself
interface microcode_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int CTRL_WIDTH = 3,
  parameter int CSEL_WIDTH = 2
);
  import microseq_pkg::*;

  localparam int DATA_WIDTH = data_width(ADDR_WIDTH, CTRL_WIDTH, CSEL_WIDTH);

  logic                         start;
  logic [ADDR_WIDTH-1:0]        start_addr;
  logic [(2**CSEL_WIDTH)-2:0]   cond_in;
  logic [ADDR_WIDTH-1:0]        rom_addr;
  logic [DATA_WIDTH-1:0]        rom_data;
  logic [CTRL_WIDTH-1:0]        ctrl_out;
  logic                         busy;
  logic                         done;
  logic                         err;

  modport master (
    output start, start_addr, cond_in, rom_data,
    input  rom_addr, ctrl_out, busy, done, err
  );

  modport slave (
    input  start, start_addr, cond_in, rom_data,
    output rom_addr, ctrl_out, busy, done, err
  );

endinterface

// File: rtl/microseq_stack.sv
// microseq_stack: small LIFO holding return addresses.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (empties the stack)
//   push, din  : push din when not full
//   pop        : discard the top entry when not empty
//   dout       : current top entry (valid when !empty)
//   empty, full: occupancy flags
module microseq_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [CW-1:0]               cnt_q;
  logic [CW-1:0]               cnt_m1;

  assign cnt_m1 = cnt_q - 1'b1;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign dout   = mem_q[cnt_m1[IW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clr)        cnt_q <= '0;
    else if (push && !full)   cnt_q <= cnt_q + 1'b1;
    else if (pop && !empty)   cnt_q <= cnt_m1;
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && push && !full) mem_q[cnt_q[IW-1:0]] <= din;
  end

endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: drives a combinational-read microcode ROM, decodes
// each word (NEXT / conditional JUMP / CALL / RET) and presents its ctrl
// field to the datapath, one microinstruction per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : microcode_sequencer_if.slave (start/start_addr command,
//                cond_in flags, rom_addr/rom_data, ctrl_out, busy, done, err)
// Build option: MICROSEQ_STACK_EN enables the return stack for CALL/RET.
// Without it CALL is an unconditional jump, RET always ends and err is 0.
module microcode_sequencer
  import microseq_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int CTRL_WIDTH  = 3,
  parameter int CSEL_WIDTH  = 2,
  parameter int STACK_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  microcode_sequencer_if.slave  bus
);

  localparam int TGT_LSB  = tgt_lsb(CTRL_WIDTH);
  localparam int CSEL_LSB = csel_lsb(ADDR_WIDTH, CTRL_WIDTH);
  localparam int OP_LSB   = op_lsb(ADDR_WIDTH, CTRL_WIDTH, CSEL_WIDTH);

  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("microcode_sequencer: STACK_DEPTH must be at least 1");
  end

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       pc_q, pc_d, pc_inc;
  logic                        done_q, done_d;
  logic [CTRL_WIDTH-1:0]       ctrl;

  op_t                         op;
  logic [CSEL_WIDTH-1:0]       csel;
  logic [ADDR_WIDTH-1:0]       tgt;
  logic [2**CSEL_WIDTH-1:0]    cond_sel;

  assign op       = op_t'(bus.rom_data[OP_LSB +: OP_W]);
  assign csel     = bus.rom_data[CSEL_LSB +: CSEL_WIDTH];
  assign tgt      = bus.rom_data[TGT_LSB +: ADDR_WIDTH];
  // Select 0 is a constant 1 so csel=0 makes JUMP unconditional.
  assign cond_sel = {bus.cond_in, 1'b1};
  assign pc_inc   = pc_q + 1'b1;

`ifdef MICROSEQ_STACK_EN
  logic                  err_q, err_d;
  logic                  stk_clr, stk_push, stk_pop, stk_empty, stk_full;
  logic [ADDR_WIDTH-1:0] stk_dout;

  microseq_stack #(.WIDTH(ADDR_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    ctrl    = '0;
`ifdef MICROSEQ_STACK_EN
    err_d    = err_q;
    stk_clr  = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pc_d    = bus.start_addr;
          state_d = ST_RUN;
`ifdef MICROSEQ_STACK_EN
          err_d   = 1'b0;
          stk_clr = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        ctrl = bus.rom_data[CTRL_LSB +: CTRL_WIDTH];
        pc_d = pc_inc;
        unique case (op)
          OP_NEXT: ;
          OP_JUMP: if (cond_sel[csel]) pc_d = tgt;
          OP_CALL: begin
`ifdef MICROSEQ_STACK_EN
            if (stk_full) begin
              // Overflow aborts the program; PC stays on the failing CALL.
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = ST_IDLE;
              pc_d    = pc_q;
            end else begin
              stk_push = 1'b1;
              pc_d     = tgt;
            end
`else
            pc_d = tgt;
`endif
          end
          OP_RET: begin
`ifdef MICROSEQ_STACK_EN
            if (!stk_empty) begin
              stk_pop = 1'b1;
              pc_d    = stk_dout;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
              pc_d    = pc_q;
            end
`else
            done_d  = 1'b1;
            state_d = ST_IDLE;
            pc_d    = pc_q;
`endif
          end
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

`ifdef MICROSEQ_STACK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.rom_addr = pc_q;
  assign bus.ctrl_out = ctrl;
  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = done_q;

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Microprogram sequencer for the calculator control path. Drives the address of an external asynchronous (combinational-read) microcode ROM, decodes each returned word into next-address control (step, conditional jump, call, return) and a control-signal field, and presents that field to the datapath one microinstruction per clock. Sits between the top-level key/command decoder, which issues `start` with an entry address, and the arithmetic datapath, which consumes `ctrl_out` and returns status flags on `cond_in`.

## Interface
- `ADDR_WIDTH`, 4: ROM address width; the program counter (PC) has this width.
- `CTRL_WIDTH`, 3: control-field width.
- `CSEL_WIDTH`, 2: condition-select field width.
- `STACK_DEPTH`, 2: return-stack entries; must be at least 1.
- `DATA_WIDTH`: derived, 2 + `CSEL_WIDTH` + `ADDR_WIDTH` + `CTRL_WIDTH` (default 11). Word layout, MSB first: `{op[1:0], csel, target, ctrl}`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `start_addr`  in  ADDR_WIDTH  entry address, captured with `start`.
- `cond_in`  in  2**CSEL_WIDTH-1  status flags; select index 0 is an internal constant 1.
- `rom_addr`  out  ADDR_WIDTH  ROM address; equals PC.
- `rom_data`  in  DATA_WIDTH  ROM word for `rom_addr`, valid in the same cycle.
- `ctrl_out`  out  CTRL_WIDTH  ctrl field of the current word while busy, otherwise 0.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when the program ends.
- `err`  out  1  sticky flag for stack overflow.

## Operation
- States:
  - IDLE: `busy`=0, `ctrl_out`=0. `start`=1 sets PC <= `start_addr`, clears the stack, clears `err`, and moves to RUN.
  - RUN: executes one word per cycle. `start` is ignored.
- Opcodes. PC+1 wraps from 2**ADDR_WIDTH-1 to 0.
  - 00 NEXT: PC <= PC+1.
  - 01 JUMP: if `cond_sel[csel]`=1, PC <= target; otherwise PC <= PC+1. `cond_sel` is `{cond_in, 1'b1}`, so csel=0 is an unconditional jump.
  - 10 CALL: push PC+1, then PC <= target. If the stack is full: set `err`, skip the push, go to IDLE, pulse `done`.
  - 11 RET: if the stack is non-empty, pop into PC. If empty: the program ends, go to IDLE, pulse `done`.
- `ctrl_out` holds the ctrl field of the word being executed for every RUN cycle, including the final RET and the overflowing CALL.
- Reset (any time, including mid-program): IDLE, PC=0, stack empty, `busy`=0, `done`=0, `err`=0, `ctrl_out`=0.

## Timing
- `rom_addr` is a register output. `ctrl_out` and the next-PC decode are combinational from `rom_data`: the ROM path is a zero-latency lookup.
- The cycle after `start` is the first RUN cycle, with `rom_addr`=`start_addr`.
- `done` is registered: it is high the cycle after the terminating word, coincident with the first IDLE cycle (`busy`=0).
- `start` is accepted in the same cycle that `done` is high.
- `err` is set coincident with `done` and holds until the next accepted `start` or reset.
- A RET pop and a CALL push never occur in the same cycle; one op executes per cycle.

## Configuration
- `MICROSEQ_STACK_EN` defined: CALL/RET and the return stack operate as above.
- `MICROSEQ_STACK_EN` undefined: no stack hardware. CALL behaves as an unconditional JUMP to target. RET always ends the program. `err` is tied to 0. `STACK_DEPTH` is ignored.

## Structure
- Package `microseq_pkg` holds:
  - the `op_t` enum (NEXT, JUMP, CALL, RET);
  - the `state_t` enum (IDLE, RUN);
  - localparam field offsets and a `DATA_WIDTH` helper function.
- Sub-module `microseq_stack`: a parameterised LIFO.
  - Ports: `clk`, `rst_n`, `clr`, `push`, `pop`, `din`, `dout`, `empty`, `full`.
  - Synchronous clear.
  - Present only when `MICROSEQ_STACK_EN` is defined.
- The ROM is instantiated outside this block.

## Test plan
- Straight line: ROM[2..4]=NEXT with ctrl 1,2,3, ROM[5]=RET. `start`, `start_addr`=2 -> `ctrl_out` 1,2,3,RET-ctrl on 4 consecutive cycles; `done` on the 5th cycle with `busy`=0.
- Conditional jump: ROM[0]=JUMP csel=1 target=8. `cond_in[0]`=1 -> next `rom_addr`=8. Repeat with `cond_in[0]`=0 -> next `rom_addr`=1.
- Call/return: ROM[0]=CALL target=6, ROM[6]=RET, ROM[1]=RET -> `rom_addr` sequence 0,6,1; `done` after 3 RUN cycles; `err`=0.
- Overflow, `STACK_DEPTH`=2: three nested CALLs -> `err`=1 and `done` on the cycle after the third CALL; the next `start` clears `err`.
- Wrap and ignore: ROM[15]=NEXT, ROM[0]=RET, `start_addr`=15 -> `rom_addr` 15 then 0. `start` pulsed while busy -> no effect.
- Reset mid-program: `rst_n`=0 in the 2nd RUN cycle -> next cycle `busy`=0, `rom_addr`=0, `ctrl_out`=0, no `done` pulse.
